// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - state encoding shared by the counter run controller
package count_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchroniser, stability filter and press pulse
// COUNT_CTRL_DEBOUNCE_EN selects the DEB_CYCLES filter; otherwise a bare synchronised falling edge.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  // A one-cycle filter degenerates to a plain edge detector on the synchronised key.
  localparam int DEB_EFF = FILTER_EN ? DEB_CYCLES : 1;
  localparam int CNT_W   = $clog2(DEB_EFF + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_EFF - 1)) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - run controller for the 4-bit counter: FSM, prescaler, wrap limit
// Debounce filtering is enabled by defining COUNT_CTRL_DEBOUNCE_EN.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int WRAP_W     = 4
) (
  input  logic              iCLK_50,
  input  logic              iRST,
  input  logic              iKEY_N,
  input  logic              iDIR_UP,
  input  logic [WRAP_W-1:0] iWRAP_LIMIT,
  input  logic              iCARRY,
  output logic              oCNT_EN,
  output logic              oCNT_UP,
  output logic              oCNT_CLR,
  output logic [ST_W-1:0]   oSTATE,
  output logic [WRAP_W-1:0] oWRAPS,
  output logic              oDONE
);

  localparam int            PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [PS_W-1:0]   r_presc;
  logic [WRAP_W-1:0] r_wraps;
  logic [WRAP_W-1:0] r_limit;
  logic              r_up;
  logic              r_clr;
  logic              w_press;
  logic              w_start;
  logic              w_tick;
  logic              w_wrap_ev;
  logic              w_hit_limit;
  logic [WRAP_W-1:0] w_wraps_inc;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_debounce (
    .i_clk   (iCLK_50),
    .i_rst   (iRST),
    .i_key_n (iKEY_N),
    .o_press (w_press)
  );

  // Prescaler holds during the clear cycle so the first enable lands PRESCALE cycles later.
  assign w_start     = (r_state == IDLE) && w_press;
  assign w_tick      = (r_state == RUN) && (r_presc == PS_LAST);
  assign w_wrap_ev   = w_tick && iCARRY;
  assign w_wraps_inc = r_wraps + 1'b1;
  assign w_hit_limit = w_wrap_ev && (r_limit != '0) && (w_wraps_inc == r_limit);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_press) w_next = RUN;
      RUN: begin
        if (w_hit_limit)  w_next = DONE;
        else if (w_press) w_next = PAUSE;
      end
      PAUSE:   if (w_press) w_next = RUN;
      DONE:    if (w_press) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_wraps <= '0;
      r_limit <= '0;
      r_up    <= 1'b1;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clr   <= w_start;
      if (w_start) begin
        r_presc <= '0;
        r_wraps <= '0;
        r_limit <= iWRAP_LIMIT;
        r_up    <= iDIR_UP;
      end else begin
        if (r_state == RUN && !r_clr)
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_wrap_ev && !(r_limit == '0 && r_wraps == '1))
          r_wraps <= w_wraps_inc;
      end
    end
  end

  assign oCNT_EN  = w_tick;
  assign oCNT_UP  = r_up;
  assign oCNT_CLR = r_clr;
  assign oSTATE   = r_state;
  assign oWRAPS   = r_wraps;
  assign oDONE    = (r_state == DONE);

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - self-checking bench for count_ctrl (PRESCALE=4, DEB_CYCLES=3)
// Honours COUNT_CTRL_DEBOUNCE_EN for press latency and the bounce scenario.
module tb_count_ctrl;

  localparam int PRESCALE = 4;
  localparam int DEB      = 3;
`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam int PRESS_D  = 2 + DEB;
`else
  localparam int PRESS_D  = 3;
`endif
  localparam int K = (PRESS_D + 3) / 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       dir_up;
  logic [3:0] wrap_limit;
  logic       carry;
  logic       cnt_en;
  logic       cnt_up;
  logic       cnt_clr;
  logic [1:0] state;
  logic [3:0] wraps;
  logic       done;

  int          checks = 0;
  int          errors = 0;
  int          run_cnt = 0;
  int          en_seen = 0;
  int          en_idx = 0;
  int          clr_seen = 0;
  logic        up_at_clr = 1'b1;
  logic [31:0] carry_mask = '0;

  typedef struct {
    logic        dir;
    logic [3:0]  lim;
    logic [31:0] mask;
    int          n_en;
    logic [1:0]  exp_state;
    logic [3:0]  exp_wraps;
  } vec_t;
  vec_t vecs[7];

  count_ctrl #(.PRESCALE(PRESCALE), .DEB_CYCLES(DEB), .WRAP_W(4)) dut (
    .iCLK_50     (clk),
    .iRST        (rst),
    .iKEY_N      (key_n),
    .iDIR_UP     (dir_up),
    .iWRAP_LIMIT (wrap_limit),
    .iCARRY      (carry),
    .oCNT_EN     (cnt_en),
    .oCNT_UP     (cnt_up),
    .oCNT_CLR    (cnt_clr),
    .oSTATE      (state),
    .oWRAPS      (wraps),
    .oDONE       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_n = 1'b1;
    rst   = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic press_key();
    key_n = 1'b0;
    repeat (PRESS_D + 2) step();
    key_n = 1'b1;
    repeat (PRESS_D + 2) step();
  endtask

  // Enables must come exactly PRESCALE RUN cycles after the previous enable or clear.
  always @(negedge clk) begin
    if (rst) begin
      run_cnt  = 0;
      en_seen  = 0;
      en_idx   = 0;
      clr_seen = 0;
      carry    = 1'b0;
    end else begin
      if (cnt_clr) begin
        run_cnt   = 0;
        en_seen   = 0;
        en_idx    = 0;
        clr_seen++;
        up_at_clr = cnt_up;
      end else if (state == 2'b01) begin
        run_cnt++;
      end
      carry = 1'b0;
      if (cnt_en) begin
        check("en_spacing", run_cnt, PRESCALE);
        check("en_in_run", state, 2'b01);
        check("en_not_clr", cnt_clr, 1'b0);
        carry = carry_mask[en_idx];
        en_seen++;
        if (en_idx < 31) en_idx++;
        run_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_en;
    logic [3:0] saved_w;

    vecs[0] = '{1'b0, 4'd2,  32'h0000_0012, 5,  2'b11, 4'd2};
    vecs[1] = '{1'b1, 4'd3,  32'hFFFF_FFFF, 3,  2'b11, 4'd3};
    vecs[2] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 17, 2'b01, 4'd15};
    vecs[3] = '{1'b0, 4'd0,  32'h0000_0000, 6,  2'b01, 4'd0};
    vecs[4] = '{1'b1, 4'd1,  32'h0000_0004, 3,  2'b11, 4'd1};
    vecs[5] = '{1'b0, 4'd5,  32'h0000_0015, 6,  2'b01, 4'd3};
    vecs[6] = '{1'b1, 4'd15, 32'h0000_000F, 5,  2'b01, 4'd4};

    rst = 1'b1; key_n = 1'b1; dir_up = 1'b1; wrap_limit = 4'd0;
    repeat (2) step();
    check("rst_state", state, 2'b00);
    check("rst_wraps", wraps, 4'd0);
    check("rst_en", cnt_en, 1'b0);
    check("rst_clr", cnt_clr, 1'b0);
    check("rst_up", cnt_up, 1'b1);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      dir_up     = vecs[i].dir;
      wrap_limit = vecs[i].lim;
      carry_mask = vecs[i].mask;
      press_key();
      check("v_clr_count", clr_seen, 1);
      check("v_clr_up", up_at_clr, vecs[i].dir);
      dir_up     = ~vecs[i].dir;
      wrap_limit = ~vecs[i].lim;
      for (int c = 0; c < 300 && en_seen < vecs[i].n_en; c++) step();
      check("v_en_count", en_seen, vecs[i].n_en);
      step();
      check("v_state", state, vecs[i].exp_state);
      check("v_wraps", wraps, vecs[i].exp_wraps);
      check("v_up", cnt_up, vecs[i].dir);
      check("v_done", done, vecs[i].exp_state == 2'b11);
      repeat (12) step();
      check("v_en_after", en_seen,
            (vecs[i].exp_state == 2'b11) ? vecs[i].n_en : vecs[i].n_en + 3);
    end

    // Reset mid-run
    do_reset();
    dir_up = 1'b0; wrap_limit = 4'd0; carry_mask = '1;
    press_key();
    for (int c = 0; c < 100 && en_seen < 3; c++) step();
    check("t1_pre_up", cnt_up, 1'b0);
    rst = 1'b1;
    step();
    check("t1_state", state, 2'b00);
    check("t1_wraps", wraps, 4'd0);
    check("t1_en", cnt_en, 1'b0);
    check("t1_up", cnt_up, 1'b1);
    check("t1_done", done, 1'b0);
    check("t1_clr", cnt_clr, 1'b0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("t1_no_clr", clr_seen, 0);
    check("t1_idle", state, 2'b00);

    // Pause and resume
    do_reset();
    dir_up = 1'b1; wrap_limit = 4'd0; carry_mask = 32'h1;
    press_key();
    press_key();
    check("t4_paused", state, 2'b10);
    saved_en = en_seen;
    saved_w  = wraps;
    repeat (50) step();
    check("t4_no_en", en_seen, saved_en);
    check("t4_hold_state", state, 2'b10);
    check("t4_hold_wraps", wraps, saved_w);
    press_key();
    check("t4_resumed", state, 2'b01);
    for (int c = 0; c < 40 && en_seen < saved_en + 2; c++) step();
    check("t4_en_resumed", en_seen >= saved_en + 2, 1'b1);

    // Press lands on the limit-reaching enable
    do_reset();
    dir_up = 1'b1; wrap_limit = 4'd6; carry_mask = '1;
    press_key();
    for (int c = 0; c < 100 && !(cnt_en && en_seen == 6 - K); c++) step();
    check("t6_sync", en_seen, 6 - K);
    repeat (4 * K - PRESS_D) step();
    key_n = 1'b0;
    repeat (PRESS_D + 1) step();
    check("t6_state", state, 2'b11);
    check("t6_wraps", wraps, 4'd6);
    check("t6_done", done, 1'b1);
    key_n = 1'b1;
    repeat (PRESS_D + 4) step();
    check("t6_still_done", state, 2'b11);
    press_key();
    check("t6_idle", state, 2'b00);
    check("t6_wraps_held", wraps, 4'd6);
    check("t6_done_low", done, 1'b0);

`ifdef COUNT_CTRL_DEBOUNCE_EN
    // Bouncing key yields a single start
    do_reset();
    dir_up = 1'b1; wrap_limit = 4'd0; carry_mask = '0;
    for (int c = 0; c < 10; c++) begin
      key_n = c[0];
      step();
    end
    key_n = 1'b0;
    repeat (20) step();
    check("t5_one_clr", clr_seen, 1);
    check("t5_run", state, 2'b01);
    key_n = 1'b1;
    repeat (10) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
